// File: rtl/mem_port_responder.sv
// Memory-mapped byte FIFO port: TX/RX FIFOs, status and control behind a
// four-word window, answering the processor bus alongside main memory.
module mem_port_responder #(
    parameter logic [4:0] BASE_ADDR = 5'd28,
    parameter int         DEPTH     = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       READ,
    input  logic       WRITE,
    input  logic [4:0] MEM_ADDR,
    input  logic [7:0] MEM_DATA_IN,
    output logic [7:0] MEM_DATA_OUT,
    output logic       DOUT_EN,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    input  logic       tx_ready,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic       rx_ready
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]    r_txMem [DEPTH];
    logic [7:0]    r_rxMem [DEPTH];
    logic [AW-1:0] r_txRd, r_txWr, r_rxRd, r_rxWr;
    logic [CW-1:0] r_txCount, r_rxCount;
    logic [1:0]    r_ctrl;
    logic          r_ovf, r_undf, r_coll;

    logic       w_hit, w_rdHit, w_wrHit, w_collEvt;
    logic [1:0] w_off;
    logic       w_txFull, w_txEmpty, w_rxFull, w_rxEmpty;
    logic       w_txPop, w_rxPush;
    logic       w_cpuPushReq, w_cpuPush, w_ovfEvt;
    logic       w_cpuPopReq, w_cpuPop, w_undfEvt;
    logic       w_clear;
    logic [7:0] w_rxHead, w_status, w_count, w_rdData;

    assign w_hit     = (MEM_ADDR[4:2] == BASE_ADDR[4:2]);
    assign w_off     = MEM_ADDR[1:0];
    assign w_rdHit   = READ && w_hit;
    assign w_wrHit   = WRITE && w_hit && !READ;
    assign w_collEvt = READ && WRITE && w_hit;

    assign w_txFull  = (r_txCount == CW'(DEPTH));
    assign w_txEmpty = (r_txCount == '0);
    assign w_rxFull  = (r_rxCount == CW'(DEPTH));
    assign w_rxEmpty = (r_rxCount == '0);

    assign tx_valid  = !w_txEmpty && r_ctrl[0];
    assign tx_data   = r_txMem[r_txRd];
    assign rx_ready  = !w_rxFull && r_ctrl[1];
    assign w_txPop   = tx_valid && tx_ready;
    assign w_rxPush  = rx_valid && rx_ready;

    // A full TX still takes a CPU byte when the consumer drains one this edge;
    // an empty RX still serves a CPU read from the byte arriving this edge.
    assign w_cpuPushReq = w_wrHit && (w_off == 2'd0);
    assign w_cpuPush    = w_cpuPushReq && (!w_txFull || w_txPop);
    assign w_ovfEvt     = w_cpuPushReq && !w_cpuPush;
    assign w_cpuPopReq  = w_rdHit && (w_off == 2'd0);
    assign w_cpuPop     = w_cpuPopReq && (!w_rxEmpty || w_rxPush);
    assign w_undfEvt    = w_cpuPopReq && !w_cpuPop;
    assign w_rxHead     = w_rxEmpty ? rx_data : r_rxMem[r_rxRd];

    assign w_clear  = w_wrHit && (w_off == 2'd2) && MEM_DATA_IN[7];
    assign w_status = {1'b0, r_coll, r_undf, r_ovf, w_txFull, w_txEmpty, w_rxFull, w_rxEmpty};
    assign w_count  = {4'(r_txCount), 4'(r_rxCount)};

    always_comb begin
        w_rdData = 8'h00;
        case (w_off)
            2'd0:    w_rdData = w_cpuPop ? w_rxHead : 8'h00;
            2'd1:    w_rdData = w_status;
            2'd2:    w_rdData = {6'b0, r_ctrl};
            default: w_rdData = w_count;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            MEM_DATA_OUT <= 8'h00;
            DOUT_EN      <= 1'b0;
            r_txRd       <= '0;
            r_txWr       <= '0;
            r_rxRd       <= '0;
            r_rxWr       <= '0;
            r_txCount    <= '0;
            r_rxCount    <= '0;
            r_ctrl       <= 2'b11;
            r_ovf        <= 1'b0;
            r_undf       <= 1'b0;
            r_coll       <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_txMem[i] <= 8'h00;
                r_rxMem[i] <= 8'h00;
            end
        end else begin
            DOUT_EN <= w_rdHit;
            if (w_rdHit)
                MEM_DATA_OUT <= w_rdData;

            if (w_cpuPush) begin
                r_txMem[r_txWr] <= MEM_DATA_IN;
                r_txWr          <= r_txWr + AW'(1);
            end
            if (w_txPop)
                r_txRd <= r_txRd + AW'(1);
            r_txCount <= r_txCount + CW'(w_cpuPush) - CW'(w_txPop);

            if (w_rxPush) begin
                r_rxMem[r_rxWr] <= rx_data;
                r_rxWr          <= r_rxWr + AW'(1);
            end
            if (w_cpuPop)
                r_rxRd <= r_rxRd + AW'(1);
            r_rxCount <= r_rxCount + CW'(w_rxPush) - CW'(w_cpuPop);

            if (w_wrHit && (w_off == 2'd2))
                r_ctrl <= MEM_DATA_IN[1:0];

            // Clearing and a fresh event in one cycle leaves the flag set.
            r_ovf  <= (r_ovf  && !w_clear) || w_ovfEvt;
            r_undf <= (r_undf && !w_clear) || w_undfEvt;
            r_coll <= (r_coll && !w_clear) || w_collEvt;
        end
    end

endmodule

// File: tb/tb_mem_port_responder.sv
// Self-checking bench for mem_port_responder: directed scenarios plus random
// traffic, checked against a queue-based model of the port.
module tb_mem_port_responder;

    localparam logic [4:0] BASE  = 5'd28;
    localparam int         DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic       rd = 1'b0, wr = 1'b0;
    logic [4:0] addr = 5'd0;
    logic [7:0] din = 8'h00;
    logic       txReady = 1'b0, rxValid = 1'b0;
    logic [7:0] rxData = 8'h00;
    logic [7:0] memDataOut, txData;
    logic       doutEn, txValid, rxReady;

    int vectors = 0;
    int miscompares = 0;

    mem_port_responder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(rstN), .READ(rd), .WRITE(wr), .MEM_ADDR(addr),
        .MEM_DATA_IN(din), .MEM_DATA_OUT(memDataOut), .DOUT_EN(doutEn),
        .tx_data(txData), .tx_valid(txValid), .tx_ready(txReady),
        .rx_data(rxData), .rx_valid(rxValid), .rx_ready(rxReady)
    );

    always #5 clk = ~clk;

    // Reference model: FIFOs as queues, flags and enables as plain bits.
    byte unsigned mTx[$];
    byte unsigned mRx[$];
    bit [1:0] mCtrl = 2'b11;
    bit       mOvf, mUndf, mColl, mEn;
    bit [7:0] mDout;

    function automatic bit expTxValid();
        return (mTx.size() != 0) && mCtrl[0];
    endfunction

    function automatic bit expRxReady();
        return (mRx.size() < DEPTH) && mCtrl[1];
    endfunction

    function automatic void modelStep(bit r, bit w, bit [4:0] a, bit [7:0] d,
                                      bit txr, bit rxv, bit [7:0] rxd, bit rn);
        bit       hit;
        int       off;
        bit [7:0] status, count, ctrlRd;
        bit       txFire, rxFire;
        if (!rn) begin
            mTx.delete();
            mRx.delete();
            mCtrl = 2'b11;
            mOvf = 0; mUndf = 0; mColl = 0;
            mEn = 0; mDout = 8'h00;
            return;
        end
        hit    = (a / 4) == (BASE / 4);
        off    = a % 4;
        status = {1'b0, mColl, mUndf, mOvf, mTx.size() == DEPTH, mTx.size() == 0,
                  mRx.size() == DEPTH, mRx.size() == 0};
        count  = 8'(mTx.size() * 16 + mRx.size());
        ctrlRd = {6'b0, mCtrl};
        txFire = expTxValid() && txr;
        rxFire = expRxReady() && rxv;
        if (txFire) void'(mTx.pop_front());
        if (rxFire) mRx.push_back(rxd);
        mEn = r && hit;
        if (w && !r && hit && off == 2 && d[7]) begin
            mOvf = 0; mUndf = 0; mColl = 0;
        end
        if (r && w && hit) mColl = 1;
        if (r && hit) begin
            case (off)
                0: if (mRx.size() > 0) mDout = mRx.pop_front();
                   else begin mDout = 8'h00; mUndf = 1; end
                1: mDout = status;
                2: mDout = ctrlRd;
                default: mDout = count;
            endcase
        end else if (w && hit) begin
            if (off == 0) begin
                if (mTx.size() < DEPTH) mTx.push_back(d);
                else mOvf = 1;
            end else if (off == 2) begin
                mCtrl = d[1:0];
            end
        end
    endfunction

    task automatic cyc(input logic rn, input logic r, input logic w, input logic [4:0] a,
                       input logic [7:0] d, input logic txr, input logic rxv,
                       input logic [7:0] rxd);
        rstN = rn; rd = r; wr = w; addr = a; din = d;
        txReady = txr; rxValid = rxv; rxData = rxd;
        modelStep(r, w, a, d, txr, rxv, rxd, rn);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1, 0, 0, 5'd0, 8'h00, 0, 0, 8'h00);
    endtask

    task automatic test_reset();
        cyc(0, 0, 0, 5'd0, 8'h00, 0, 0, 8'h00);
        cyc(0, 0, 0, 5'd0, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (doutEn !== 1'b0 || memDataOut !== 8'h00 || txValid !== 1'b0 || rxReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL reset_outputs: got en=%b dout=%h txv=%b rxr=%b expected 0 00 0 1",
                     doutEn, memDataOut, txValid, rxReady);
        end
        cyc(1, 1, 0, 5'd29, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (doutEn !== 1'b1 || memDataOut !== 8'h05 || mDout !== 8'h05) begin
            miscompares++;
            $display("[TB] FAIL reset_status: got en=%b dout=%h expected 1 05", doutEn, memDataOut);
        end
        cyc(1, 1, 0, 5'd30, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (doutEn !== 1'b1 || memDataOut !== 8'h03) begin
            miscompares++;
            $display("[TB] FAIL reset_ctrl: got en=%b dout=%h expected 1 03", doutEn, memDataOut);
        end
        idle();
        vectors++;
        if (doutEn !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL dout_en_drop: got %b expected 0", doutEn);
        end
    endtask

    task automatic test_tx_overflow();
        for (int i = 0; i < 5; i++) begin
            cyc(1, 0, 1, 5'd28, 8'hA1 + 8'(i), 0, 0, 8'h00);
            vectors++;
            if (txValid !== 1'b1) begin
                miscompares++;
                $display("[TB] FAIL tx_valid_fill: got %b expected 1", txValid);
            end
        end
        cyc(1, 1, 0, 5'd31, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut !== 8'h40) begin
            miscompares++;
            $display("[TB] FAIL tx_count: got %h expected %h", memDataOut, mDout);
        end
        cyc(1, 1, 0, 5'd29, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout) begin
            miscompares++;
            $display("[TB] FAIL ovf_status: got %h expected %h", memDataOut, mDout);
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (txValid !== 1'b1 || txData !== mTx[0] || txData !== 8'hA1 + 8'(i)) begin
                miscompares++;
                $display("[TB] FAIL tx_drain: got v=%b data=%h expected 1 %h", txValid, txData, mTx[0]);
            end
            cyc(1, 0, 0, 5'd0, 8'h00, 1, 0, 8'h00);
        end
        vectors++;
        if (txValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL tx_empty_valid: got %b expected 0", txValid);
        end
    endtask

    task automatic test_back_to_back();
        byte unsigned vals[3] = '{8'h11, 8'h22, 8'h33};
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 5'd0, 8'h00, 0, 1, vals[i]);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 1, 0, 5'd28, 8'h00, 0, 0, 8'h00);
            vectors++;
            if (doutEn !== 1'b1 || memDataOut !== mDout || memDataOut !== (i < 3 ? vals[i] : 8'h00)) begin
                miscompares++;
                $display("[TB] FAIL rx_b2b_%0d: got en=%b dout=%h expected 1 %h", i, doutEn, memDataOut, mDout);
            end
        end
        cyc(1, 1, 0, 5'd29, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut[5] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL undf_status: got %h expected %h", memDataOut, mDout);
        end
    endtask

    task automatic test_full_concurrent();
        byte unsigned seen[$];
        cyc(1, 0, 1, 5'd30, 8'h83, 0, 0, 8'h00);
        for (int i = 0; i < 4; i++) cyc(1, 0, 1, 5'd28, 8'hB0 + 8'(i), 0, 0, 8'h00);
        cyc(1, 0, 1, 5'd28, 8'h5A, 1, 0, 8'h00);
        cyc(1, 1, 0, 5'd29, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut[4] !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL full_push_status: got %h expected %h", memDataOut, mDout);
        end
        cyc(1, 1, 0, 5'd31, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut[7:4] !== 4'd4) begin
            miscompares++;
            $display("[TB] FAIL full_push_count: got %h expected %h", memDataOut, mDout);
        end
        for (int i = 0; i < 8 && txValid; i++) begin
            seen.push_back(txData);
            cyc(1, 0, 0, 5'd0, 8'h00, 1, 0, 8'h00);
        end
        vectors++;
        if (seen.size() != 4 || seen[3] !== 8'h5A || seen[0] !== 8'hB1) begin
            miscompares++;
            $display("[TB] FAIL full_push_order: got %0d bytes last=%h expected 4 bytes last=5a",
                     seen.size(), seen.size() > 0 ? seen[seen.size()-1] : 8'h00);
        end
    endtask

    task automatic test_collision();
        cyc(1, 0, 0, 5'd0, 8'h00, 0, 1, 8'h77);
        cyc(1, 1, 1, 5'd28, 8'h99, 0, 0, 8'h00);
        vectors++;
        if (doutEn !== 1'b1 || memDataOut !== 8'h77) begin
            miscompares++;
            $display("[TB] FAIL coll_read: got en=%b dout=%h expected 1 77", doutEn, memDataOut);
        end
        vectors++;
        if (txValid !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL coll_tx_unchanged: got txv=%b expected 0", txValid);
        end
        cyc(1, 1, 0, 5'd29, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut[6] !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL coll_status: got %h expected %h", memDataOut, mDout);
        end
        cyc(1, 0, 1, 5'd30, 8'h83, 0, 0, 8'h00);
        cyc(1, 1, 0, 5'd29, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut[6:4] !== 3'b000) begin
            miscompares++;
            $display("[TB] FAIL flag_clear: got %h expected %h", memDataOut, mDout);
        end
    endtask

    task automatic test_miss();
        cyc(1, 1, 0, 5'd3, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (doutEn !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL miss_dout_en: got %b expected 0", doutEn);
        end
        cyc(1, 0, 1, 5'd0, 8'hEE, 0, 0, 8'h00);
        cyc(1, 0, 1, 5'd2, 8'h80, 0, 0, 8'h00);
        cyc(1, 1, 0, 5'd31, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== mDout || memDataOut !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL miss_count: got %h expected %h", memDataOut, mDout);
        end
    endtask

    task automatic test_reset_mid();
        cyc(1, 0, 1, 5'd28, 8'hC1, 0, 1, 8'hD1);
        cyc(1, 0, 1, 5'd28, 8'hC2, 0, 1, 8'hD2);
        cyc(0, 1, 0, 5'd28, 8'h00, 1, 1, 8'hD3);
        vectors++;
        if (doutEn !== 1'b0 || memDataOut !== 8'h00 || txValid !== 1'b0 || rxReady !== 1'b1) begin
            miscompares++;
            $display("[TB] FAIL mid_reset: got en=%b dout=%h txv=%b rxr=%b expected 0 00 0 1",
                     doutEn, memDataOut, txValid, rxReady);
        end
        cyc(1, 1, 0, 5'd31, 8'h00, 0, 0, 8'h00);
        vectors++;
        if (memDataOut !== 8'h00) begin
            miscompares++;
            $display("[TB] FAIL mid_reset_count: got %h expected 00", memDataOut);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 600; n++) begin
            logic       r, w;
            logic [4:0] a;
            logic [7:0] d;
            r = ($urandom_range(0, 3) == 0);
            w = ($urandom_range(0, 2) == 0);
            a = ($urandom_range(0, 7) == 0) ? 5'($urandom) : BASE + 5'($urandom_range(0, 3));
            d = 8'($urandom);
            if (a == BASE + 5'd2 && $urandom_range(0, 3) != 0) d[1:0] = 2'b11;
            cyc(1, r, w, a, d, 1'($urandom), 1'($urandom), 8'($urandom));
            vectors++;
            if (doutEn !== mEn || (mEn && memDataOut !== mDout)) begin
                miscompares++;
                $display("[TB] FAIL rand_read@%0d: got en=%b dout=%h expected %b %h",
                         n, doutEn, memDataOut, mEn, mDout);
            end
            vectors++;
            if (txValid !== expTxValid() || (expTxValid() && txData !== mTx[0])) begin
                miscompares++;
                $display("[TB] FAIL rand_tx@%0d: got v=%b data=%h expected %b %h",
                         n, txValid, txData, expTxValid(), mTx.size() > 0 ? mTx[0] : 8'h00);
            end
            vectors++;
            if (rxReady !== expRxReady()) begin
                miscompares++;
                $display("[TB] FAIL rand_rx_ready@%0d: got %b expected %b", n, rxReady, expRxReady());
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_overflow();
        test_back_to_back();
        test_full_concurrent();
        test_collision();
        test_miss();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
